// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the 256-point radix-4 FFT sequencer.
// Holds the state encoding, the per-stage mux table and the twiddle index rule.
package fft_ctrl_pkg;

    localparam int NUM_STAGE = 4;
    localparam int NUM_BANK  = 4;
    localparam int CNT_W     = 6;
    localparam int TWI_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        UNLOAD,
        FIN
    } state_e;

    typedef struct packed {
        logic       m11;
        logic [1:0] m12;
        logic [1:0] m13;
        logic       m14;
        logic       m21;
        logic       m22;
        logic       m23;
        logic       m24;
    } mux_sel_t;

    localparam mux_sel_t MUX_STRAIGHT = '{
        m11: 1'b0, m12: 2'd1, m13: 2'd1, m14: 1'b1,
        m21: 1'b0, m22: 1'b0, m23: 1'b1, m24: 1'b1
    };

    localparam mux_sel_t STAGE_MUX [NUM_STAGE] = '{
        MUX_STRAIGHT, MUX_STRAIGHT, MUX_STRAIGHT, MUX_STRAIGHT
    };

    // Stage s steps the twiddle index by 4^s; the last stage uses W^0 only.
    function automatic logic [TWI_W-1:0] tw_idx(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       s);
        logic [TWI_W-1:0] base;
        base = {2'b00, cnt};
        if (s == 2'd3) return '0;
        return base << {s, 1'b0};
    endfunction

endpackage

// File: rtl/fft_ctrl256_if.sv
// Control bus between the FFT sequencer and the bank/PE datapath.
interface fft_ctrl256_if #(
    parameter int ADDR_BIT = 6,
    parameter int TW_BIT   = 8
);
    import fft_ctrl_pkg::*;

    logic start;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic busy;
    logic done;
    logic en;
    logic we;
    logic re;
    logic m0;
    logic m11;
    logic [1:0] m12;
    logic [1:0] m13;
    logic m14;
    logic m21;
    logic m22;
    logic m23;
    logic m24;
    logic bypass_en;
    logic [NUM_BANK-1:0][ADDR_BIT-1:0] addr_read;
    logic [NUM_BANK-1:0][ADDR_BIT-1:0] addr_write;
    logic [TW_BIT-1:0] tw_addr;

    modport master (
        input  start, in_valid,
        output in_ready, out_valid, busy, done, en, we, re, m0,
               m11, m12, m13, m14, m21, m22, m23, m24, bypass_en,
               addr_read, addr_write, tw_addr
    );

    modport slave (
        output start, in_valid,
        input  in_ready, out_valid, busy, done, en, we, re, m0,
               m11, m12, m13, m14, m21, m22, m23, m24, bypass_en,
               addr_read, addr_write, tw_addr
    );

endinterface

// File: rtl/fft_wb_delay.sv
// Read-to-writeback delay line: carries {valid, addr} through STAGES registers
// so writes (or output beats) line up with RAM read data.
module fft_wb_delay #(
    parameter int STAGES = 1,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o
);

    logic [STAGES:1]         vld_pipe_q;
    logic [STAGES:1][AW-1:0] addr_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q[1]  <= vld_i;
            addr_pipe_q[1] <= addr_i;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

    assign vld_o  = vld_pipe_q[STAGES];
    assign addr_o = addr_pipe_q[STAGES];

endmodule

// File: rtl/fft_ctrl256.sv
// Sequencer for the 256-point radix-4 FFT: load, four in-place stages, unload.
// All datapath controls are decoded from the state, the beat counter and the delay line.
module fft_ctrl256
    import fft_ctrl_pkg::*;
#(
    parameter int ADDR_BIT = 6,
    parameter int N_STAGE  = 4,
    parameter int RD_LAT   = 1,
    parameter int TW_BIT   = 8
) (
    input  logic          clk,
    input  logic          rst,
    fft_ctrl256_if.master bus
);

    localparam logic [ADDR_BIT-1:0] CNT_MAX = '1;
    localparam logic [1:0]          S_LAST  = 2'(N_STAGE - 1);

    state_e              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;
    logic [1:0]          s_q, s_d;
    logic                rd_done_q, rd_done_d;

    logic                dly_vld;
    logic [ADDR_BIT-1:0] dly_addr;
    logic                last_beat;

    logic     en, we, re, m0, bypass_en, in_ready, out_valid, done;
    mux_sel_t mux;
    logic [NUM_BANK-1:0][ADDR_BIT-1:0] ar, aw;
    logic [TW_BIT-1:0] tw;

    fft_wb_delay #(
        .STAGES (RD_LAT),
        .AW     (ADDR_BIT)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (re),
        .addr_i (cnt_q),
        .vld_o  (dly_vld),
        .addr_o (dly_addr)
    );

    // The delayed copy of read 63 marks the last write of a stage / last output beat.
    assign last_beat = dly_vld && (dly_addr == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            rd_done_q <= rd_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        rd_done_d = rd_done_q;
        en        = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        m0        = 1'b0;
        bypass_en = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        mux       = '0;
        ar        = '0;
        aw        = '0;
        tw        = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    s_d     = '0;
                end
            end
            LOAD: begin
                en       = 1'b1;
                in_ready = 1'b1;
                we       = bus.in_valid;
                aw       = {NUM_BANK{cnt_q}};
                if (bus.in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = CALC;
                        s_d     = '0;
                    end
                end
            end
            CALC: begin
                en    = 1'b1;
                re    = 1'b1;
                m0    = 1'b1;
                mux   = STAGE_MUX[s_q];
                ar    = {NUM_BANK{cnt_q}};
                tw    = TW_BIT'(tw_idx(CNT_W'(cnt_q), s_q));
                we    = dly_vld;
                aw    = {NUM_BANK{dly_addr}};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) state_d = DRAIN;
            end
            DRAIN: begin
                // Next stage reads only after this stage's final write has issued.
                en = 1'b1;
                m0 = 1'b1;
                we = dly_vld;
                aw = {NUM_BANK{dly_addr}};
                if (last_beat) begin
                    cnt_d = '0;
                    if (s_q == S_LAST) begin
                        state_d   = UNLOAD;
                        rd_done_d = 1'b0;
                    end else begin
                        s_d     = s_q + 1'b1;
                        state_d = CALC;
                    end
                end
            end
            UNLOAD: begin
                en        = 1'b1;
                bypass_en = 1'b1;
                mux       = STAGE_MUX[s_q];
                out_valid = dly_vld;
                if (!rd_done_q) begin
                    re    = 1'b1;
                    ar    = {NUM_BANK{cnt_q}};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) rd_done_d = 1'b1;
                end
                if (last_beat) state_d = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_d   = IDLE;
                s_d       = '0;
                cnt_d     = '0;
                rd_done_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.en         = en;
    assign bus.we         = we;
    assign bus.re         = re;
    assign bus.m0         = m0;
    assign bus.bypass_en  = bypass_en;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.done       = done;
    assign bus.busy       = (state_q != IDLE);
    assign bus.m11        = mux.m11;
    assign bus.m12        = mux.m12;
    assign bus.m13        = mux.m13;
    assign bus.m14        = mux.m14;
    assign bus.m21        = mux.m21;
    assign bus.m22        = mux.m22;
    assign bus.m23        = mux.m23;
    assign bus.m24        = mux.m24;
    assign bus.addr_read  = ar;
    assign bus.addr_write = aw;
    assign bus.tw_addr    = tw;

endmodule

// File: tb/tb_fft_ctrl256.sv
// Directed/randomized bench for fft_ctrl256: every cycle of a transform is
// compared against the expected control word derived from the phase timeline.
module tb_fft_ctrl256;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_CALC   = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_UNLOAD = 4;
    localparam int P_FIN    = 5;

    // {m11, m12, m13, m14, m21, m22, m23, m24} for the straight-through setting
    localparam logic [9:0] MUX_ST = {1'b0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fft_ctrl256_if #(.ADDR_BIT(6), .TW_BIT(8)) bus ();

    fft_ctrl256 #(.ADDR_BIT(6), .N_STAGE(4), .RD_LAT(1), .TW_BIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rep(input int a);
        logic [5:0] v;
        v = a[5:0];
        return {4{v}};
    endfunction

    // Stage s advances the twiddle index by 4^s per beat, modulo the 256-entry ROM.
    function automatic int tw_model(input int s, input int c);
        if (s == 3) return 0;
        return (c * (4 ** s)) % 256;
    endfunction

    task automatic check(input string tag, input int ph, input int s, input int c, input logic v);
        logic [6:0] e_ctl;
        logic [9:0] e_mux;
        logic       e_en, e_m0, care_en, care_m0, care_ar, care_aw, care_tw;
        logic [23:0] e_ar, e_aw;
        logic [9:0] o_mux;
        string t;
        e_ctl = '0; e_mux = '0; e_en = 1'b0; e_m0 = 1'b0;
        care_en = 1'b1; care_m0 = 1'b1; care_ar = 1'b0; care_aw = 1'b0; care_tw = 1'b0;
        e_ar = '0; e_aw = '0;
        case (ph)
            P_IDLE: ;
            P_LOAD: begin
                e_ctl = {1'b1, 1'b1, 1'b0, 1'b0, v, 1'b0, 1'b0};
                e_en = 1'b1; care_aw = v; e_aw = rep(c);
            end
            P_CALC: begin
                e_ctl = {1'b1, 1'b0, 1'b0, 1'b0, (c > 0), 1'b1, 1'b0};
                e_en = 1'b1; e_m0 = 1'b1; e_mux = MUX_ST;
                care_ar = 1'b1; e_ar = rep(c);
                care_aw = (c > 0); e_aw = rep(c - 1);
                care_tw = 1'b1;
            end
            P_DRAIN: begin
                e_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
                e_en = 1'b1; care_m0 = 1'b0; care_aw = 1'b1; e_aw = rep(63);
            end
            P_UNLOAD: begin
                e_ctl = {1'b1, 1'b0, (c > 0), 1'b0, 1'b0, (c < 64), 1'b1};
                e_en = 1'b1; care_m0 = 1'b0; e_mux = MUX_ST;
                care_ar = (c < 64); e_ar = rep(c);
            end
            default: begin
                e_ctl = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
                care_en = 1'b0; care_m0 = 1'b0;
            end
        endcase
        t = $sformatf("%s s%0d c%0d", tag, s, c);
        o_mux = {bus.m11, bus.m12, bus.m13, bus.m14, bus.m21, bus.m22, bus.m23, bus.m24};
        chk({t, " ctl"}, 32'({bus.busy, bus.in_ready, bus.out_valid, bus.done,
                              bus.we, bus.re, bus.bypass_en}), 32'(e_ctl));
        chk({t, " mux"}, 32'(o_mux), 32'(e_mux));
        if (care_en) chk({t, " en"}, 32'(bus.en), 32'(e_en));
        if (care_m0) chk({t, " m0"}, 32'(bus.m0), 32'(e_m0));
        if (care_ar) chk({t, " addr_read"}, 32'(bus.addr_read), 32'(e_ar));
        if (care_aw) chk({t, " addr_write"}, 32'(bus.addr_write), 32'(e_aw));
        if (care_tw) chk({t, " tw_addr"}, 32'(bus.tw_addr), tw_model(s, c));
    endtask

    // mode 0: continuous, 1: gap every 3rd cycle, 2: random gaps.
    // ab_s/ab_c: reset at that CALC point; st_c: pulse start at that UNLOAD beat.
    task automatic run(input int mode, input int ab_s, input int ab_c, input int st_c);
        int   beats, n;
        logic v;
        bus.start = 1'b1;
        #1 check("idle_start", P_IDLE, 0, 0, 1'b0);
        step();
        bus.start = 1'b0;
        beats = 0;
        n = 0;
        while (beats < 64 && n < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 3) != 2;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = v;
            #1 check("load", P_LOAD, 0, beats, v);
            if (v) beats++;
            n++;
            step();
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 64; c++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                #1 check("calc", P_CALC, s, c, 1'b0);
                if (s == ab_s && c == ab_c) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    bus.in_valid = 1'b0;
                    #1 check("abort", P_IDLE, s, c, 1'b0);
                    return;
                end
                step();
            end
            #1 check("drain", P_DRAIN, s, 64, 1'b0);
            step();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c <= 64; c++) begin
            bus.start = (c == st_c);
            #1 check("unload", P_UNLOAD, 3, c, 1'b0);
            step();
            bus.start = 1'b0;
        end
        #1 check("fin", P_FIN, 3, 0, 1'b0);
        step();
        #1 check("post", P_IDLE, 0, 0, 1'b0);
    endtask

    initial begin
        int ndone, t_done, n_re, n_we, n_ov, n_busy;
        rst = 1'b1;
        bus.start = 1'b1;
        bus.in_valid = 1'b0;
        step();
        step();
        #1 check("reset", P_IDLE, 0, 0, 1'b0);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat ($urandom_range(1, 5)) begin
            step();
            #1 check("idle", P_IDLE, 0, 0, 1'b0);
        end

        run(1, -1, -1, -1);
        run(0, -1, -1, -1);
        run(2, -1, -1, -1);

        run(0, 2, 17, -1);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            #1 if (bus.done || bus.busy) ndone++;
        end
        chk("abort quiet", ndone, 0);
        run(0, -1, -1, -1);

        run(2, -1, -1, 10);

        // Free-running transform with a stray start in UNLOAD; k=1 is the first LOAD cycle.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        ndone = 0; t_done = 0; n_re = 0; n_we = 0; n_ov = 0; n_busy = 0;
        for (int k = 1; k <= 420; k++) begin
            #1;
            if (bus.done) begin ndone++; t_done = k; end
            if (bus.re) n_re++;
            if (bus.we) n_we++;
            if (bus.out_valid) n_ov++;
            if (bus.busy) n_busy++;
            bus.start = (k == 350);
            step();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("free done count", ndone, 1);
        chk("free done cycle", t_done, 390);
        chk("free re cycles", n_re, 320);
        chk("free we cycles", n_we, 320);
        chk("free out_valid cycles", n_ov, 64);
        chk("free busy cycles", n_busy, 390);
        #1 chk("free busy end", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_ctrl256.md
Name: fft_ctrl256

Overview:
- Sequencer (initiator) for the 256-point radix-4 FFT datapath: four 64-word RAM banks, PE and bank/PE muxes.
- Drives every datapath control input: bank enables/addresses, mux selects, bypass and twiddle index.
- Runs load, four in-place compute stages and unload, then pulses done.

Parameters:
ADDR_BIT, 6, per-bank address width (64 words/bank)
N_STAGE, 4, radix-4 stages (log4 256)
RD_LAT, 1, RAM read latency in cycles; also the read-to-writeback delay
TW_BIT, 8, twiddle ROM index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin transform; sampled only in IDLE
in_valid  in  1  source presents 4 samples on datapath in0..in3
in_ready  out  1  controller accepts input this cycle
out_valid  out  1  datapath mem0_o..mem3_o carry 4 result words this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of unload
en, we, re  out  1 each  RAM bank enable / write / read
m0  out  1  bank input select: 0 = external in, 1 = PE out
m11, m14  out  1 each  PE input muxes
m12, m13  out  2 each  PE input muxes
m21, m22, m23, m24  out  1 each  PE output muxes
bypass_en  out  1  PE pass-through
addr_read  out  4*ADDR_BIT  per-bank read address; bank b in bits [ADDR_BIT*(b+1)-1 : ADDR_BIT*b]
addr_write  out  4*ADDR_BIT  per-bank write address; same packing
tw_addr  out  TW_BIT  twiddle ROM index; issued in the same cycle as re, so it aligns with RAM data

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
  - Reset values: all outputs 0, state IDLE, stage 0, cnt 0.
  - rst asserted mid-operation aborts the transform on the next edge.
  - No done pulse after an abort; RAM contents are undefined.
- FSM states: IDLE, LOAD, CALC, DRAIN, UNLOAD, FIN. cnt is 6 bits; s is 2 bits.
- IDLE:
  - en=0, we=0, re=0.
  - start → LOAD with cnt=0.
- LOAD:
  - en=1, m0=0, in_ready=1.
  - we = in_valid; addr_write = cnt in all 4 banks.
  - cnt increments only on in_valid.
  - When cnt=63 is accepted: go to CALC with s=0 and cnt=0.
  - A gap in in_valid stalls LOAD with no write.
- CALC:
  - en=1, re=1, m0=1, bypass_en=0; addr_read = cnt in all banks.
  - tw_addr = ({2'b0,cnt} << 2s) mod 256 for s<3; tw_addr = 0 for s=3.
  - Writeback: we=1 with addr_write = cnt delayed RD_LAT cycles, through a shift register of addr and valid.
  - After the read of cnt=63 go to DRAIN.
- DRAIN:
  - re=0; writeback continues for RD_LAT cycles.
  - Then: if s<3, s++, cnt=0, back to CALC. If s=3, go to UNLOAD.
  - A stage never starts reading before the prior stage's last write has issued. This prevents a read-after-write hazard.
- UNLOAD:
  - re=1, we=0, bypass_en=1; addr_read = cnt.
  - out_valid = delayed read-valid (RD_LAT).
  - Output is valid-only with no backpressure; the sink must accept every beat.
  - After the last out_valid, go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Mux selects in CALC/UNLOAD come from the package table STAGE_MUX[s]. Value for all stages: m11=0, m12=1, m13=1, m14=1, m21=0, m22=0, m23=1, m24=1 (straight-through). Outside CALC/UNLOAD all selects are 0.
- start while busy is ignored. start coincident with rst: rst wins.
- Latency with continuous in_valid:
  - 64 LOAD cycles, plus 4*(64+RD_LAT) CALC/DRAIN cycles, plus 64+RD_LAT UNLOAD cycles, plus 1 FIN cycle.
  - With RD_LAT=1 that is 390 cycles from the first LOAD cycle to done.

Decomposition:
- Package fft_ctrl_pkg holds:
  - state enum
  - N_STAGE and bank count constants
  - STAGE_MUX table type and contents
  - twiddle-index function
- One sub-module, fft_wb_delay: RD_LAT-deep shift register carrying {valid, addr}. It is used for both the writeback path and out_valid.

Test Plan:
- Reset: assert rst for 2 cycles → all outputs 0, busy=0. Then start=1 → busy=1 and in_ready=1 on the next cycle.
- Load with gaps: 64 beats with in_valid low every 3rd cycle → we equals in_valid. addr_write runs 0..63 in all banks, then CALC begins with re=1, addr_read=0.
- Compute sequencing: continuous run → per stage, re=1 for exactly 64 cycles and we lags re by 1 cycle with matching addr.
  - tw_addr at cnt=5 reads 5, 20, 80, 0 for stages 0..3.
  - One DRAIN cycle separates stages.
- Unload/done: out_valid=1 for exactly 64 consecutive cycles with bypass_en=1. done pulses once at cycle 390 after LOAD start, then busy=0.
- Abort: rst at CALC stage 2, cnt=17 → next cycle we=0, re=0, state IDLE, no done pulse. A following start runs a full, correct sequence.
- Ignored start: pulse start during UNLOAD → sequence timing unchanged and exactly one done.
